// File: rtl/uart_echo_sequencer_if.sv
// Port-mapped bus between the echo sequencer (master) and the UART register file (slave).
// The sequencer owns the address, the write data and both strobes; the UART returns read data.
interface uart_echo_sequencer_if;
    logic [7:0] port_id;
    logic [7:0] data_out;
    logic [7:0] data_in;
    logic       read_strobe;
    logic       write_strobe;

    modport master (
        output port_id,
        output data_out,
        output read_strobe,
        output write_strobe,
        input  data_in
    );

    modport slave (
        input  port_id,
        input  data_out,
        input  read_strobe,
        input  write_strobe,
        output data_in
    );
endinterface

// File: rtl/uart_echo_sequencer.sv
// Polls a UART status register, pulls received bytes into a small FIFO and echoes them back
// to the UART transmitter in order, using two-cycle (setup, strobe) bus accesses.
module uart_echo_sequencer #(
    parameter logic [7:0] STATUS_PORT  = 8'h00,
    parameter logic [7:0] DATA_PORT    = 8'h01,
    parameter int         RX_READY_BIT = 0,
    parameter int         TX_FULL_BIT  = 1,
    parameter int         DEPTH        = 4,
    parameter int         POLL_DIV     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         interrupt,
    uart_echo_sequencer_if.master        bus,
    output logic                         busy,
    output logic [4:0]                   fifo_level,
    output logic [7:0]                   echo_count
);
    localparam int         PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] POLL_LOAD = 8'(POLL_DIV - 1);
    localparam logic [4:0] DEPTH_L   = 5'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, ST_SET, ST_STB, DEC, RX_SET, RX_STB, TX_SET, TX_STB
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic             rx_ready_q, rx_ready_d;
    logic             tx_full_q, tx_full_d;
    logic [7:0]       port_id_q, port_id_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             read_strobe_q, read_strobe_d;
    logic             write_strobe_q, write_strobe_d;
    logic             busy_q, busy_d;
    logic [4:0]       level_q, level_d;
    logic [7:0]       echo_count_q, echo_count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic             push;
    logic             pop;

    always_comb begin
        state_d      = state_q;
        rx_ready_d   = rx_ready_q;
        tx_full_d    = tx_full_q;
        echo_count_d = echo_count_q;
        push         = 1'b0;
        pop          = 1'b0;

        case (state_q)
            IDLE:    if (enable && (timer_q == 8'd0 || interrupt)) state_d = ST_SET;
            ST_SET:  state_d = ST_STB;
            ST_STB: begin
                rx_ready_d = bus.data_in[RX_READY_BIT];
                tx_full_d  = bus.data_in[TX_FULL_BIT];
                state_d    = DEC;
            end
            // Receive wins over transmit; a full FIFO leaves the byte waiting in the UART.
            DEC: begin
                if (rx_ready_q && level_q < DEPTH_L)       state_d = RX_SET;
                else if (level_q != 5'd0 && !tx_full_q)    state_d = TX_SET;
                else                                       state_d = IDLE;
            end
            RX_SET:  state_d = RX_STB;
            RX_STB: begin
                push    = 1'b1;
                state_d = enable ? ST_SET : IDLE;
            end
            TX_SET:  state_d = TX_STB;
            TX_STB: begin
                pop          = 1'b1;
                echo_count_d = echo_count_q + 8'd1;
                state_d      = enable ? ST_SET : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The poll timer restarts whenever IDLE is (re)entered and counts down while resting there.
        if (state_q == IDLE && state_d == IDLE) begin
            timer_d = (timer_q != 8'd0) ? timer_q - 8'd1 : 8'd0;
        end else begin
            timer_d = POLL_LOAD;
        end

        // Bus outputs are registered from the next state so they line up with the state itself.
        port_id_d  = port_id_q;
        data_out_d = data_out_q;
        case (state_d)
            ST_SET: port_id_d = STATUS_PORT;
            RX_SET: port_id_d = DATA_PORT;
            TX_SET: begin
                port_id_d  = DATA_PORT;
                data_out_d = mem_q[rd_ptr_q];
            end
            default: ;
        endcase
        read_strobe_d  = (state_d == ST_STB) || (state_d == RX_STB);
        write_strobe_d = (state_d == TX_STB);
        busy_d         = (state_d != IDLE);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = bus.data_in;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q + 5'(push) - 5'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            timer_q        <= POLL_LOAD;
            rx_ready_q     <= 1'b0;
            tx_full_q      <= 1'b0;
            port_id_q      <= 8'h00;
            data_out_q     <= 8'h00;
            read_strobe_q  <= 1'b0;
            write_strobe_q <= 1'b0;
            busy_q         <= 1'b0;
            level_q        <= 5'd0;
            echo_count_q   <= 8'h00;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            rx_ready_q     <= rx_ready_d;
            tx_full_q      <= tx_full_d;
            port_id_q      <= port_id_d;
            data_out_q     <= data_out_d;
            read_strobe_q  <= read_strobe_d;
            write_strobe_q <= write_strobe_d;
            busy_q         <= busy_d;
            level_q        <= level_d;
            echo_count_q   <= echo_count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            mem_q          <= mem_d;
        end
    end

    assign bus.port_id      = port_id_q;
    assign bus.data_out     = data_out_q;
    assign bus.read_strobe  = read_strobe_q;
    assign bus.write_strobe = write_strobe_q;
    assign busy             = busy_q;
    assign fifo_level       = level_q;
    assign echo_count       = echo_count_q;
endmodule
